// File: rtl/ram_access_ctrl.sv
// Request/response front end for a synchronous single-port RAM: credit-based
// acceptance, 4-entry read-response FIFO. Optional perf counters: RAM_ACCESS_CTRL_PERF_CNT_EN.
module ram_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    ram_ce,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
`ifdef RAM_ACCESS_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]             perf_rd_cnt,
  output logic [15:0]             perf_wr_cnt
`endif
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;

  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];

  logic [CNT_W-1:0] used;
  logic             accept;
  logic             rd_acc;
  logic             wr_acc;
  logic             push;
  logic             pop;

  // A credit is held from read acceptance until its response is popped,
  // so the FIFO cannot overflow.
  assign used      = count + CNT_W'(rd_inflight);
  assign req_ready = rst_n & (used < CNT_W'(DEPTH));
  assign rsp_valid = (count != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_comb begin
    accept   = req_valid & req_ready;
    rd_acc   = accept & ~req_we;
    wr_acc   = accept & req_we & (|req_strb);
    push     = rd_inflight;
    pop      = rsp_valid & rsp_ready;
    ram_ce   = rd_acc | wr_acc;
    ram_we   = wr_acc ? req_strb : STRB_W'(0);
    ram_addr = req_addr;
    ram_din  = req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= rd_acc;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Response storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

`ifdef RAM_ACCESS_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else begin
      if (rd_acc) perf_rd_cnt <= perf_rd_cnt + 16'd1;
      if (wr_acc) perf_wr_cnt <= perf_wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed table, multi-cycle corner
// sequences and random traffic against a transaction-level reference model.
module tb_ram_access_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = 16;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we;
  logic [SW-1:0] req_strb;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_ce;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
`ifdef RAM_ACCESS_CTRL_PERF_CNT_EN
  logic [15:0]   perf_rd_cnt, perf_wr_cnt;
`endif

  ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_ACCESS_CTRL_PERF_CNT_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM with byte enables
  logic [DW-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we != '0) begin
        for (int b = 0; b < int'(SW); b++)
          if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  // Reference model: memory image, ordered expected responses with the cycle
  // they become visible, and operation counts.
  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } rsp_t;

  logic [DW-1:0] shadow [256];
  rsp_t          exp_q[$];
  int            cyc;
  int            rd_cnt_m, wr_cnt_m;
  int            checks, failures;

  // DUT values sampled mid-cycle by tick()
  logic          s_ready, s_ce, s_rv;
  logic [DW-1:0] s_rd;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(SW); b++)
      if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check at negedge against the model, advance model.
  task automatic tick(input logic v, input logic we, input logic [SW-1:0] s,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr,
                      output logic acc);
    logic exp_ready, exp_ce, exp_rv;
    req_valid = v; req_we = we; req_strb = s; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    exp_ready = (exp_q.size() < 4);
    acc       = v && exp_ready;
    exp_ce    = acc && (!we || s != '0);
    exp_rv    = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    s_ready = req_ready; s_ce = ram_ce; s_rv = rsp_valid; s_rd = rsp_rdata;
    check("req_ready", DW'(req_ready), DW'(exp_ready));
    check("ram_ce", DW'(ram_ce), DW'(exp_ce));
    check("ram_we", DW'(ram_we), DW'((exp_ce && we) ? s : SW'(0)));
    check("ram_addr", DW'(ram_addr), DW'(a));
    check("ram_din", ram_din, d);
    check("rsp_valid", DW'(rsp_valid), DW'(exp_rv));
    if (exp_rv) check("rsp_rdata", rsp_rdata, exp_q[0].data);
    @(posedge clk);
    if (exp_rv && rr) void'(exp_q.pop_front());
    if (acc) begin
      if (we) begin
        if (s != '0) begin
          shadow[a] = merge(shadow[a], d, s);
          wr_cnt_m++;
        end
      end else begin
        exp_q.push_back('{data: shadow[a], avail: cyc + 2});
        rd_cnt_m++;
      end
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    logic          v, we;
    logic [SW-1:0] s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rr;
    logic          e_ce, e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;

  vec_t          tbl [8];
  logic          acc;
  int            n_acc, n_pop, start;
  int            pop_cyc[$];

  task automatic check_perf(input string tag);
`ifdef RAM_ACCESS_CTRL_PERF_CNT_EN
    check({tag, "_perf_rd"}, DW'(perf_rd_cnt), DW'(16'(rd_cnt_m)));
    check({tag, "_perf_wr"}, DW'(perf_wr_cnt), DW'(16'(wr_cnt_m)));
`endif
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; rd_cnt_m = 0; wr_cnt_m = 0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    ram_dout = '0;
    tbl[0] = '{1'b1, 1'b1, 16'hFFFF, 8'h10, D1, 1'b1, 1'b1, 1'b0, '0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 8'h10, '0, 1'b1, 1'b1, 1'b0, '0};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 8'h00, '0, 1'b1, 1'b0, 1'b0, '0};
    tbl[3] = '{1'b1, 1'b1, 16'h0001, 8'h20, {{15{8'hFF}}, 8'hAA}, 1'b1, 1'b1, 1'b1, D1};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 8'h20, '0, 1'b1, 1'b1, 1'b0, '0};
    tbl[5] = '{1'b1, 1'b1, 16'h0000, 8'h20, {16{8'h55}}, 1'b1, 1'b0, 1'b0, '0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 8'h00, '0, 1'b1, 1'b0, 1'b1, 128'hAA};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, '0, 1'b1, 1'b0, 1'b0, '0};

    // Reset state with a request presented
    rst_n = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_strb = '1; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("rst_ram_ce", DW'(ram_ce), DW'(0));
    check("rst_ram_we", DW'(ram_we), DW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_perf("init");

    // Directed write/read table
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].v, tbl[i].we, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].rr, acc);
      check($sformatf("tbl%0d_ce", i), DW'(s_ce), DW'(tbl[i].e_ce));
      check($sformatf("tbl%0d_rv", i), DW'(s_rv), DW'(tbl[i].e_rv));
      if (tbl[i].e_rv) check($sformatf("tbl%0d_rd", i), s_rd, tbl[i].e_rd);
    end
    check_perf("tbl");

    // Distinct contents at 0..7 so ordering is observable
    for (int i = 0; i < 8; i++)
      tick(1'b1, 1'b1, '1, AW'(i), {16{8'(i + 1)}}, 1'b1, acc);

    // Backpressure: only four reads fit while responses are held
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, '0, AW'(n_acc), '0, 1'b0, acc);
      if (s_ready) n_acc++;
    end
    check("bp_accepted_held", DW'(n_acc), DW'(4));
    n_pop = 0;
    for (int i = 0; i < 40 && (n_acc < 6 || exp_q.size() > 0); i++) begin
      tick(n_acc < 6, 1'b0, '0, AW'(n_acc), '0, 1'b1, acc);
      if (n_acc < 6 && s_ready) n_acc++;
      if (s_rv) n_pop++;
    end
    check("bp_accepted_total", DW'(n_acc), DW'(6));
    check("bp_responses", DW'(n_pop), DW'(6));

    // Back-to-back reads with free-flowing responses
    n_acc = 0; start = cyc;
    pop_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      tick(n_acc < 8, 1'b0, '0, AW'(n_acc), '0, 1'b1, acc);
      if (n_acc < 8 && s_ready) n_acc++;
      if (s_rv) pop_cyc.push_back(cyc - 1);
    end
    check("b2b_accepted", DW'(n_acc), DW'(8));
    check("b2b_responses", DW'(pop_cyc.size()), DW'(8));
    if (pop_cyc.size() == 8) begin
      check("b2b_first_latency", DW'(pop_cyc[0] - start), DW'(2));
      check("b2b_span", DW'(pop_cyc[7] - pop_cyc[0]), DW'(7));
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 4) != 0, 1'($urandom), (($urandom % 4) == 0) ? SW'(0) : SW'($urandom),
           AW'($urandom % 16), {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 3) != 0, acc);
    end
    check_perf("rand");

    // Reset with two responses queued and one read in flight
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    check("pre_rst_drained", DW'(exp_q.size()), DW'(0));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, AW'(i + 1), '0, 1'b0, acc);
    check("pre_rst_queued", DW'(rsp_valid), DW'(1));
    req_valid = 1'b1; req_we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("mid_rst_req_ready", DW'(req_ready), DW'(0));
    check("mid_rst_ram_ce", DW'(ram_ce), DW'(0));
    exp_q.delete(); rd_cnt_m = 0; wr_cnt_m = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_perf("post_rst");
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, AW'(i + 5), '0, 1'b1, acc);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    check("post_rst_drained", DW'(exp_q.size()), DW'(0));
    check_perf("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
